// File: rtl/pe_mult_pipe.sv
// pe_mult_pipe: elastic two-stage signed multiplier front end of the parallel PE.
// Stage 1 registers one beat of LANES int16 neuron/weight pairs plus the last flag.
// Stage 2 registers the LANES sign-extended products that feed the accumulation tree.
// Both stages use valid/ready handshakes, so at most two beats are held in flight.
// Optional feature macro: PE_BEAT_CNT_EN adds the beat_cnt output, which counts
// output handoffs since the last out_last handoff.
module pe_mult_pipe #(
  parameter int unsigned LANES = 32,
  parameter int unsigned DW    = 16,
  parameter int unsigned PW    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] neuron,
  input  logic [LANES*DW-1:0] weight,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*PW-1:0] mult_result,
  output logic                out_last,
`ifdef PE_BEAT_CNT_EN
  output logic [15:0]         beat_cnt,
`endif
  output logic                busy
);

  // Stage 1: operand capture
  logic                s1_valid_q, s1_valid_d;
  logic [LANES*DW-1:0] s1_neuron_q, s1_neuron_d;
  logic [LANES*DW-1:0] s1_weight_q, s1_weight_d;
  logic                s1_last_q, s1_last_d;

  // Stage 2: product register driving the output
  logic                s2_valid_q, s2_valid_d;
  logic [LANES*PW-1:0] s2_prod_q, s2_prod_d;
  logic                s2_last_q, s2_last_d;

  // Handshake qualifiers
  logic                s1_adv;
  logic                s2_adv;
  logic                out_xfer;

  // Per-lane multiplier operands, widened to PW before multiplying
  logic [LANES*PW-1:0] prod;
  logic signed [PW-1:0] lane_a;
  logic signed [PW-1:0] lane_b;

  // Flow control; in_ready sees out_ready combinationally but never in_valid
  always_comb begin
    s2_adv   = s1_valid_q && (!s2_valid_q || out_ready);
    in_ready = rst_n && (!s1_valid_q || s2_adv);
    s1_adv   = in_valid && in_ready;
    out_xfer = s2_valid_q && out_ready;
  end

  // Signed lane products; PW >= 2*DW so the truncated PW-bit product is exact
  always_comb begin
    prod   = '0;
    lane_a = '0;
    lane_b = '0;
    for (int j = 0; j < LANES; j++) begin
      lane_a = PW'($signed(s1_neuron_q[DW*j +: DW]));
      lane_b = PW'($signed(s1_weight_q[DW*j +: DW]));
      prod[PW*j +: PW] = lane_a * lane_b;
    end
  end

  // Stage 1 next state: load on accept, empty when its beat moves on without refill
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_neuron_d = s1_neuron_q;
    s1_weight_d = s1_weight_q;
    s1_last_d   = s1_last_q;
    if (s1_adv) begin
      s1_valid_d  = 1'b1;
      s1_neuron_d = neuron;
      s1_weight_d = weight;
      s1_last_d   = in_last;
    end else if (s2_adv) begin
      s1_valid_d  = 1'b0;
    end
  end

  // Stage 2 next state: products hold after handoff until the next load
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_prod_d  = s2_prod_q;
    s2_last_d  = s2_last_q;
    if (s2_adv) begin
      s2_valid_d = 1'b1;
      s2_prod_d  = prod;
      s2_last_d  = s1_last_q;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  // Pipeline registers with synchronous active-low reset discarding in-flight beats
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_neuron_q <= '0;
      s1_weight_q <= '0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_prod_q   <= '0;
      s2_last_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_neuron_q <= s1_neuron_d;
      s1_weight_q <= s1_weight_d;
      s1_last_q   <= s1_last_d;
      s2_valid_q  <= s2_valid_d;
      s2_prod_q   <= s2_prod_d;
      s2_last_q   <= s2_last_d;
    end
  end

`ifdef PE_BEAT_CNT_EN
  logic [15:0] beat_cnt_q, beat_cnt_d;

  // Handoff counter: clears on the last beat of a vector, saturates at all-ones
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (out_xfer) begin
      if (s2_last_q) begin
        beat_cnt_d = '0;
      end else if (beat_cnt_q != 16'hFFFF) begin
        beat_cnt_d = beat_cnt_q + 16'd1;
      end
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign beat_cnt = beat_cnt_q;
`else
  logic unused_out_xfer;
  assign unused_out_xfer = out_xfer;
`endif

  // Output drive
  always_comb begin
    out_valid   = s2_valid_q;
    mult_result = s2_prod_q;
    out_last    = s2_last_q;
    busy        = s1_valid_q | s2_valid_q;
  end

endmodule
